// File: rtl/lut_config_loader.sv
// Serial-to-parallel configuration loader for the CLB LUT SRAMs.
// Collects MEM_SIZE data bits plus one even-parity bit per word and commits each good word with a one-hot cen pulse.
module lut_config_loader #(
    parameter int ADDR_BITS = 4,
    parameter int MEM_SIZE  = 2**ADDR_BITS,
    parameter int NUM_LUTS  = 2
) (
    input  logic                cclk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    input  logic                cfg_bit,
    output logic                cfg_ready,
    output logic [MEM_SIZE-1:0] config_out,
    output logic [NUM_LUTS-1:0] cen,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_err
);

    // state   | meaning
    // IDLE    | waiting for cfg_start
    // SHIFT   | collecting data bits of the current word
    // PARITY  | waiting for the parity bit of the current word
    // COMMIT  | one-cycle cen pulse for the current LUT
    // DONE    | every LUT committed
    // ERROR   | parity failure, sequence aborted
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY,
        ST_COMMIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int CNT_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int IDX_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LUTS - 1);

    state_t              state;
    logic [MEM_SIZE-1:0] sreg;
    logic [CNT_W-1:0]    count;
    logic [IDX_W-1:0]    lut_idx;

    always_ff @(posedge cclk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            count      <= '0;
            lut_idx    <= '0;
            cfg_ready  <= 1'b0;
            cfg_busy   <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            cen        <= '0;
            config_out <= '0;
        end else begin
            cen <= '0;
            // A start in any state begins a fresh sequence; an in-flight cen pulse has already been driven.
            if (cfg_start) begin
                state     <= ST_SHIFT;
                sreg      <= '0;
                count     <= '0;
                lut_idx   <= '0;
                cfg_done  <= 1'b0;
                cfg_err   <= 1'b0;
                cfg_ready <= 1'b1;
                cfg_busy  <= 1'b1;
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (cfg_valid) begin
                            sreg  <= {sreg[MEM_SIZE-2:0], cfg_bit};
                            count <= count + CNT_W'(1);
                            if (count == CNT_LAST) begin
                                state <= ST_PARITY;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (cfg_valid) begin
                            cfg_ready <= 1'b0;
                            if ((^sreg ^ cfg_bit) == 1'b0) begin
                                state      <= ST_COMMIT;
                                config_out <= sreg;
                                cen        <= NUM_LUTS'(1) << lut_idx;
                            end else begin
                                state    <= ST_ERROR;
                                cfg_busy <= 1'b0;
                                cfg_err  <= 1'b1;
                            end
                        end
                    end
                    ST_COMMIT: begin
                        if (lut_idx == IDX_LAST) begin
                            state    <= ST_DONE;
                            cfg_busy <= 1'b0;
                            cfg_done <= 1'b1;
                        end else begin
                            state     <= ST_SHIFT;
                            lut_idx   <= lut_idx + IDX_W'(1);
                            count     <= '0;
                            cfg_ready <= 1'b1;
                        end
                    end
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                    end
                    default: begin
                        state     <= ST_IDLE;
                        cfg_ready <= 1'b0;
                        cfg_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader with 4-bit words and two LUTs.
module tb_lut_config_loader;

    logic       cclk;
    logic       rst;
    logic       cfg_start;
    logic       cfg_valid;
    logic       cfg_bit;
    logic       cfg_ready;
    logic [3:0] config_out;
    logic [1:0] cen;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    lut_config_loader #(
        .ADDR_BITS(2),
        .MEM_SIZE (4),
        .NUM_LUTS (2)
    ) dut (
        .cclk      (cclk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .config_out(config_out),
        .cen       (cen),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    // cen must never carry more than one hot bit
    always @(negedge cclk) begin
        if (!rst) begin
            n_cmp++;
            if (!$onehot0(cen)) begin
                n_bad++;
                $display("FAIL cen_onehot: got %b required at most one bit set", cen);
            end
        end
    end

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        cfg_valid = 1'b1;
        cfg_bit   = b;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w, input logic p, input int gap);
        for (int i = 3; i >= 0; i--) begin
            send_bit(w[i]);
            repeat (gap) tick();
        end
        send_bit(p);
    endtask

    task automatic do_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({cfg_ready, cfg_busy, cfg_done, cfg_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b required 0000", {cfg_ready, cfg_busy, cfg_done, cfg_err});
        end
        n_cmp++;
        if ({cen, config_out} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_data: got cen=%b cfg=%b required 00/0000", cen, config_out);
        end
    endtask

    task automatic test_two_luts(input int gap);
        do_start();
        n_cmp++;
        if ({cfg_ready, cfg_busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL start_flags(gap %0d): got %b required 11", gap, {cfg_ready, cfg_busy});
        end
        send_word(4'b1011, 1'b1, gap);
        n_cmp++;
        if (cen !== 2'b01 || config_out !== 4'b1011) begin
            n_bad++;
            $display("FAIL commit0(gap %0d): got cen=%b cfg=%b required 01/1011", gap, cen, config_out);
        end
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL commit0_ready(gap %0d): got %b required 0", gap, cfg_ready);
        end
        tick();
        n_cmp++;
        if (cen !== 2'b00 || config_out !== 4'b1011 || cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL after_commit0(gap %0d): got cen=%b cfg=%b rdy=%b required 00/1011/1", gap, cen, config_out, cfg_ready);
        end
        send_word(4'b0010, 1'b1, gap);
        n_cmp++;
        if (cen !== 2'b10 || config_out !== 4'b0010) begin
            n_bad++;
            $display("FAIL commit1(gap %0d): got cen=%b cfg=%b required 10/0010", gap, cen, config_out);
        end
        tick();
        n_cmp++;
        if (cen !== 2'b00 || {cfg_done, cfg_busy, cfg_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL done(gap %0d): got cen=%b done/busy/rdy=%b required 00/100", gap, cen, {cfg_done, cfg_busy, cfg_ready});
        end
    endtask

    task automatic test_parity_err();
        do_start();
        n_cmp++;
        if (cfg_done !== 1'b0) begin
            n_bad++;
            $display("FAIL start_clears_done: got %b required 0", cfg_done);
        end
        send_word(4'b1011, 1'b0, 0);
        n_cmp++;
        if ({cfg_err, cfg_busy, cfg_ready} !== 3'b100 || cen !== 2'b00) begin
            n_bad++;
            $display("FAIL parity_err: got err/busy/rdy=%b cen=%b required 100/00", {cfg_err, cfg_busy, cfg_ready}, cen);
        end
        tick();
        n_cmp++;
        if (cen !== 2'b00 || config_out !== 4'b0010 || cfg_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_hold: got cen=%b cfg=%b err=%b required 00/0010/1", cen, config_out, cfg_err);
        end
        do_start();
        n_cmp++;
        if (cfg_err !== 1'b0 || cfg_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL err_clear: got err=%b busy=%b required 0/1", cfg_err, cfg_busy);
        end
    endtask

    task automatic test_rst_mid();
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({cfg_ready, cfg_busy, cfg_done, cfg_err, cen, config_out} !== 10'b0) begin
            n_bad++;
            $display("FAIL rst_mid: got rdy/busy/done/err=%b cen=%b cfg=%b required all 0",
                     {cfg_ready, cfg_busy, cfg_done, cfg_err}, cen, config_out);
        end
        send_bit(1'b1);
        send_bit(1'b1);
        n_cmp++;
        if (cen !== 2'b00 || cfg_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_idle: got cen=%b rdy=%b required 00/0", cen, cfg_ready);
        end
        do_start();
        send_word(4'b1100, 1'b0, 0);
        n_cmp++;
        if (cen !== 2'b01 || config_out !== 4'b1100) begin
            n_bad++;
            $display("FAIL rst_fresh: got cen=%b cfg=%b required 01/1100", cen, config_out);
        end
        tick();
    endtask

    task automatic test_restart();
        do_start();
        send_word(4'b0110, 1'b0, 0);
        n_cmp++;
        if (cen !== 2'b01 || config_out !== 4'b0110) begin
            n_bad++;
            $display("FAIL restart_lut0: got cen=%b cfg=%b required 01/0110", cen, config_out);
        end
        tick();
        send_bit(1'b1);
        send_bit(1'b1);
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        n_cmp++;
        if (cen !== 2'b00 || config_out !== 4'b0110 || {cfg_busy, cfg_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL restart_state: got cen=%b cfg=%b busy/rdy=%b required 00/0110/11", cen, config_out, {cfg_busy, cfg_ready});
        end
        send_word(4'b1001, 1'b0, 0);
        n_cmp++;
        if (cen !== 2'b01 || config_out !== 4'b1001) begin
            n_bad++;
            $display("FAIL restart_commit: got cen=%b cfg=%b required 01/1001", cen, config_out);
        end
        tick();
    endtask

    task automatic test_idle_done_valid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) send_bit(1'b1);
        n_cmp++;
        if ({cfg_ready, cfg_busy} !== 2'b00 || cen !== 2'b00 || config_out !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_valid: got rdy/busy=%b cen=%b cfg=%b required 00/00/0000", {cfg_ready, cfg_busy}, cen, config_out);
        end
        test_two_luts(0);
        repeat (3) send_bit(1'b1);
        n_cmp++;
        if ({cfg_done, cfg_busy, cfg_ready} !== 3'b100 || cen !== 2'b00 || config_out !== 4'b0010) begin
            n_bad++;
            $display("FAIL done_valid: got done/busy/rdy=%b cen=%b cfg=%b required 100/00/0010",
                     {cfg_done, cfg_busy, cfg_ready}, cen, config_out);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        test_reset();
        test_two_luts(0);
        test_two_luts(3);
        test_parity_err();
        test_rst_mid();
        test_restart();
        test_idle_done_valid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
